// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the 40-by-8 sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int Q_W   = 32;
    localparam int D_W   = 8;
    localparam int P_W   = Q_W + D_W;
    localparam int CNT_W = $clog2(Q_W);

    localparam logic [Q_W-1:0] Q_ERR = '1;
    localparam logic [D_W-1:0] R_ERR = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
(
    input  logic [D_W-1:0] prem,
    input  logic           in_bit,
    input  logic [D_W-1:0] divisor,
    output logic [D_W-1:0] prem_next,
    output logic           qbit
);

    logic [D_W:0]   trial;
    logic [D_W-1:0] diff;

    assign trial = {prem, in_bit};
    assign qbit  = (trial >= {1'b0, divisor});
    // When the subtraction is taken the true result is below divisor, so the
    // low D_W bits of the modular difference are exact.
    assign diff      = trial[D_W-1:0] - divisor;
    assign prem_next = qbit ? diff : trial[D_W-1:0];

endmodule

// File: rtl/seq_div_40by8.sv
// rtl/seq_div_40by8.sv - radix-2 restoring divider, 40-bit dividend by 8-bit divisor
module seq_div_40by8
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [P_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           ready,
    output logic           done,
    output logic [Q_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    state_t           state;
    state_t           state_nxt;
    logic [D_W-1:0]   dvs_r;
    logic [D_W-1:0]   prem_r;
    logic [Q_W-1:0]   dlo_r;
    logic [Q_W-1:0]   qacc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [D_W-1:0]   step_prem;
    logic             step_qbit;
    logic             in_div0;
    logic             in_ovf;

    assign in_div0 = (divisor == '0);
    // Quotient fits in Q_W bits only if the top dividend byte is below divisor.
    assign in_ovf  = (dividend[P_W-1:Q_W] >= divisor);

    div_step u_step (
        .prem      (prem_r),
        .in_bit    (dlo_r[Q_W-1]),
        .divisor   (dvs_r),
        .prem_next (step_prem),
        .qbit      (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = (in_div0 || in_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_r == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvs_r       <= '0;
            prem_r      <= '0;
            dlo_r       <= '0;
            qacc_r      <= '0;
            cnt_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs_r  <= divisor;
                        prem_r <= dividend[P_W-1:Q_W];
                        dlo_r  <= dividend[Q_W-1:0];
                        qacc_r <= '0;
                        cnt_r  <= CNT_W'(Q_W - 1);
                        // Zero divisor takes precedence over overflow.
                        if (in_div0) begin
                            quotient    <= Q_ERR;
                            remainder   <= R_ERR;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (in_ovf) begin
                            quotient    <= Q_ERR;
                            remainder   <= R_ERR;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    prem_r <= step_prem;
                    dlo_r  <= {dlo_r[Q_W-2:0], 1'b0};
                    qacc_r <= {qacc_r[Q_W-2:0], step_qbit};
                    cnt_r  <= cnt_r - 1'b1;
                    if (cnt_r == '0) begin
                        quotient    <= {qacc_r[Q_W-2:0], step_qbit};
                        remainder   <= step_prem;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_40by8.sv
// tb/tb_seq_div_40by8.sv - directed self-checking bench for seq_div_40by8
module tb_seq_div_40by8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [39:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        ready;
    logic        done;
    logic [31:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seq_div_40by8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op, then count cycles from acceptance until done is seen.
    task automatic run_op(input logic [39:0] a, input logic [7:0] b,
                          output int lat, output bit rdy_seen);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (ready) rdy_seen = 1'b1;
        end
    endtask

    int          lat;
    bit          rdy_seen;
    int          np;
    int          last;
    int          seen_done;
    logic [31:0] ra;
    logic [7:0]  rb;
    logic [7:0]  rr;
    logic [39:0] rp;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_outputs", {quotient, remainder, div_by_zero, overflow}, 0);
        rst = 1'b0;

        // 1000 / 7
        run_op(40'd1000, 8'd7, lat, rdy_seen);
        check("basic_lat", lat, 33);
        check("basic_ready_in_run", rdy_seen, 0);
        check("basic_ready_in_done", ready, 0);
        check("basic_q", quotient, 142);
        check("basic_r", remainder, 6);
        check("basic_flags", {div_by_zero, overflow}, 0);
        repeat (3) @(negedge clk);
        check("basic_hold", {quotient, remainder}, {32'd142, 8'd6});
        check("basic_idle_ready", ready, 1);

        // Largest non-overflowing case
        run_op(40'hFE_FFFF_FFFF, 8'hFF, lat, rdy_seen);
        check("max_lat", lat, 33);
        check("max_q", quotient, 32'hFFFF_FFFF);
        check("max_r", remainder, 8'hFE);
        check("max_flags", {div_by_zero, overflow}, 0);

        // Divide by zero
        run_op(40'h12_3456_789A, 8'd0, lat, rdy_seen);
        check("dbz_lat", lat, 1);
        check("dbz_flags", {div_by_zero, overflow}, 2'b10);
        check("dbz_q", quotient, 32'hFFFF_FFFF);
        check("dbz_r", remainder, 8'hFF);

        // Overflow
        run_op(40'h01_0000_0000, 8'd1, lat, rdy_seen);
        check("ovf_lat", lat, 1);
        check("ovf_flags", {div_by_zero, overflow}, 2'b01);
        check("ovf_qr", {quotient, remainder}, {32'hFFFF_FFFF, 8'hFF});

        // Zero divisor wins over overflow
        run_op(40'hFF_0000_0000, 8'd0, lat, rdy_seen);
        check("prec_flags", {div_by_zero, overflow}, 2'b10);

        // Normal result clears the error flags
        run_op(40'd50, 8'd5, lat, rdy_seen);
        check("clear_flags", {div_by_zero, overflow, quotient, remainder}, {2'b00, 32'd10, 8'd0});

        // Reset during cycle T+10 aborts the op
        @(negedge clk);
        dividend = 40'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_outputs", {done, quotient, remainder, div_by_zero, overflow}, 0);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run_op(40'd1000, 8'd7, lat, rdy_seen);
        check("abort_rerun", {lat[7:0], quotient, remainder}, {8'd33, 32'd142, 8'd6});

        // start and operand changes during RUN are ignored
        @(negedge clk);
        dividend = 40'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (i < 28) begin
                start    = i[0];
                dividend = 40'd200 + 40'(i);
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_lat", lat, 33);
        check("ignore_result", {quotient, remainder}, {32'd142, 8'd6});

        // start held high: one done every 34 cycles
        @(negedge clk);
        dividend = 40'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        np = 0;
        last = 0;
        for (int i = 0; i < 200 && np < 3; i++) begin
            @(negedge clk);
            if (done) begin
                if (np > 0) check("b2b_interval", cyc - last, 34);
                check("b2b_q", quotient, 142);
                last = cyc;
                np++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", np, 3);

        // Round trip through a 32x8 product (with an optional remainder)
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = 8'($urandom_range(255, 1));
            rr = (i % 2 == 0) ? 8'd0 : 8'($urandom_range(int'(rb) - 1, 0));
            rp = 40'(ra) * 40'(rb) + 40'(rr);
            run_op(rp, rb, lat, rdy_seen);
            check("roundtrip", {lat[7:0], quotient, remainder, div_by_zero, overflow},
                  {8'd33, ra, rr, 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div_40by8.md
Name: seq_div_40by8

Overview:
Sequential radix-2 restoring divider. Divides a 40-bit dividend by an 8-bit divisor, giving a 32-bit quotient and an 8-bit remainder at one quotient bit per clock. It performs the inverse of the team's 32x8 array multiplier: a 40-bit product and its 8-bit multiplier factor go in, and the 32-bit multiplicand comes back out. It sits beside the multiplier in the arithmetic datapath and uses a start/ready/done handshake.

Parameters:
Q_W, 32, quotient width; also the number of iteration cycles
D_W, 8, divisor and remainder width; dividend width is Q_W+D_W (40)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a division; sampled only when ready=1
dividend  in  40  dividend; sampled on the accepted start edge only
divisor  in  8  divisor; sampled on the accepted start edge only
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse; results valid during this cycle
quotient  out  32  result; held until the next accepted start
remainder  out  8  result; held until the next accepted start
div_by_zero  out  1  error flag for the last operation; held with results
overflow  out  1  error flag for the last operation; held with results

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0. Reset in any state aborts the operation and produces no done pulse.
- States:
  - IDLE: ready=1. On start=1, register the operands, then:
    - divisor==0: go to DONE with div_by_zero=1.
    - else dividend[39:32] >= divisor: go to DONE with overflow=1 (quotient would not fit in 32 bits).
    - else: go to RUN. Partial remainder (9 bits) = {0,dividend[39:32]}; count=31.
  - RUN: ready=0. One iteration per cycle:
    - t = {prem[7:0], next dividend bit}, bits taken MSB-first from dividend[31] down to dividend[0].
    - If t >= divisor: prem=t-divisor and qbit=1; else prem=t and qbit=0.
    - qbit shifts into the quotient from the LSB.
    - Exactly 32 RUN cycles; after count==0 go to DONE.
  - DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
- Output update: quotient, remainder and flags update only on the edge into DONE.
  - Normal result: remainder=prem[7:0]; both flags 0.
  - Error result: quotient=32'hFFFF_FFFF, remainder=8'hFF; the non-applicable flag is 0.
- Latency, with start accepted at the edge ending cycle T:
  - normal: done high in cycle T+33;
  - error: done high in cycle T+1.
- Input stability: start while ready=0 (RUN or DONE) is ignored. Input changes after acceptance have no effect.
- Back-to-back: start held high is accepted in the IDLE cycle that follows DONE. Throughput is one op per 34 cycles.
- Flag precedence: if divisor==0, div_by_zero=1 and overflow=0.
- Invariants for every normal result: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparams Q_W=32, D_W=8, P_W=Q_W+D_W, CNT_W=$clog2(Q_W);
  - error-fill constants Q_ERR=all ones and R_ERR=all ones.
- Sub-module div_step (combinational, one restoring iteration):
  - inputs: prem[D_W-1:0], in_bit, divisor;
  - outputs: new prem, qbit.
- The top level holds the FSM, the counter, the operand/quotient shift registers and the output registers.

Test Plan:
- dividend=40'd1000, divisor=8'd7 -> done in T+33, quotient=142, remainder=6, both flags 0; ready low T+1..T+33.
- dividend=40'hFE_FFFF_FFFF, divisor=8'hFF -> quotient=32'hFFFF_FFFF, remainder=8'hFE, no flags (max non-overflow case).
- divisor=0 with any dividend -> done in T+1, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=8'hFF. Also dividend=40'h01_0000_0000 with divisor=1 -> overflow=1, done in T+1.
- Start a division, assert rst during cycle T+10 -> ready=1, all outputs 0 from the next cycle; no done pulse. A new start then completes correctly.
- Toggle start and change operands during RUN -> ignored; the first op's result is unchanged. Start held high continuously -> done pulses every 34 cycles.
- Round-trip of 1000 random A (32b) and B≠0 (8b) through the 32x8 multiplier, then into this block -> quotient==A, remainder==0, no flags.
